// File: rtl/dpll_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dpll_pkg : shared constants, FSM state type and trim-word encoder for the
//            DCO frequency-locking controller.
// Revision  : 1.0
// ----------------------------------------------------------------------------
package dpll_pkg;

  localparam int TRIM_W  = 26;
  localparam int NSTAGE  = 13;
  localparam int IDX_MAX = 26;
  localparam int IDX_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    TRACK = 2'd2,
    LOCK  = 2'd3
  } state_e;

  // Primary bits fill first; a secondary bit only turns on once every primary
  // bit is already on.
  function automatic logic [TRIM_W-1:0] encode_trim(input logic [IDX_W-1:0] idx);
    logic [TRIM_W-1:0] enc;
    int                i;
    enc = '0;
    i   = int'(idx);
    for (int k = 0; k < NSTAGE; k++) begin
      enc[k]          = (k < i);
      enc[NSTAGE + k] = (i > NSTAGE) && (k < i - NSTAGE);
    end
    return enc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpll_ref_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dpll_ref_sync : two-flop synchronizer for the reference clock plus a delay
//                 flop for rising-edge detection in the DCO clock domain.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module dpll_ref_sync (
  input  logic clock_i,
  input  logic reset_i,
  input  logic ref_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic dly_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= ref_i;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~dly_q;

endmodule
`default_nettype wire

// File: rtl/dpll_freq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dpll_freq_ctrl : counts DCO cycles per reference period and steps the ring
//                  oscillator trim toward the programmed divider ratio.
//                  Define DPLL_AVG_EN to compare two-period sums instead.
// Revision       : 1.0
// ----------------------------------------------------------------------------
module dpll_freq_ctrl
  import dpll_pkg::*;
#(
  parameter int DIV_W    = 5,
  parameter int CNT_W    = 7,
  parameter int TOL      = 1,
  parameter int LOCK_N   = 4,
  parameter int TRIM_RST = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              osc_i,
  input  logic [DIV_W-1:0]  div_i,
  output logic [TRIM_W-1:0] trim_o,
  output logic [IDX_W-1:0]  trim_idx_o,
  output logic              locked_o,
  output logic              update_o
);

  localparam int STK_W = $clog2(LOCK_N + 1);
  localparam int EW    = ((CNT_W > DIV_W) ? CNT_W : DIV_W) + 3;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(IDX_MAX);
  localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(TRIM_RST);
  localparam logic [STK_W-1:0] STK_LAST = STK_W'(LOCK_N - 1);
  localparam logic [STK_W-1:0] STK_FULL = STK_W'(LOCK_N);

  state_e              state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [IDX_W-1:0]    idx_q,    idx_d;
  logic [TRIM_W-1:0]   trim_q,   trim_d;
  logic                locked_q, locked_d;
  logic                update_q, update_d;
  logic [STK_W-1:0]    streak_q, streak_d;

  logic                ref_edge;
  logic signed [EW-1:0] meas;
  logic signed [EW-1:0] band_hi;
  logic signed [EW-1:0] band_lo;
  logic                go_up;
  logic                go_down;

  dpll_ref_sync u_ref_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .ref_i   (osc_i),
    .edge_o  (ref_edge)
  );

`ifdef DPLL_AVG_EN
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [CNT_W:0]   sum;

  // Without a prior period the sum degenerates to twice the current count.
  assign sum     = have_prev_q ? ({1'b0, cnt_q} + {1'b0, prev_q}) : {cnt_q, 1'b0};
  assign meas    = EW'(sum);
  assign band_hi = EW'(div_i) + EW'(div_i) + EW'(2 * TOL);
  assign band_lo = EW'(div_i) + EW'(div_i) - EW'(2 * TOL);
`else
  assign meas    = EW'(cnt_q);
  assign band_hi = EW'(div_i) + EW'(TOL);
  assign band_lo = EW'(div_i) - EW'(TOL);
`endif

  // A saturated count is always too slow a reference, whatever div is.
  assign go_up   = (cnt_q == CNT_MAX) || (meas > band_hi);
  assign go_down = !go_up && (meas < band_lo);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    locked_d = locked_q;
    update_d = 1'b0;
    streak_d = streak_q;
`ifdef DPLL_AVG_EN
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
`endif

    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (ref_edge) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (!enable_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      locked_d = 1'b0;
      streak_d = '0;
`ifdef DPLL_AVG_EN
      prev_d      = '0;
      have_prev_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
        end
        ARM: begin
          if (ref_edge) begin
            state_d  = TRACK;
            streak_d = '0;
`ifdef DPLL_AVG_EN
            have_prev_d = 1'b0;
`endif
          end
        end
        TRACK, LOCK: begin
          if (ref_edge) begin
            update_d = 1'b1;
`ifdef DPLL_AVG_EN
            prev_d      = cnt_q;
            have_prev_d = 1'b1;
`endif
            if (go_up || go_down) begin
              if (go_up && (idx_q != IDX_TOP)) begin
                idx_d = idx_q + 1'b1;
              end else if (go_down && (idx_q != '0)) begin
                idx_d = idx_q - 1'b1;
              end
              streak_d = '0;
              locked_d = 1'b0;
              state_d  = TRACK;
            end else if (state_q == TRACK) begin
              if (streak_q >= STK_LAST) begin
                state_d  = LOCK;
                locked_d = 1'b1;
                streak_d = STK_FULL;
              end else begin
                streak_d = streak_q + 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign trim_d = encode_trim(idx_d);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= IDX_INIT;
      trim_q   <= encode_trim(IDX_INIT);
      locked_q <= 1'b0;
      update_q <= 1'b0;
      streak_q <= '0;
`ifdef DPLL_AVG_EN
      prev_q      <= '0;
      have_prev_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      trim_q   <= trim_d;
      locked_q <= locked_d;
      update_q <= update_d;
      streak_q <= streak_d;
`ifdef DPLL_AVG_EN
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
`endif
    end
  end

  assign trim_o     = trim_q;
  assign trim_idx_o = idx_q;
  assign locked_o   = locked_q;
  assign update_o   = update_q;

endmodule
`default_nettype wire

// File: tb/tb_dpll_freq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dpll_freq_ctrl : directed and random reference periods against a
//                     period-level model of the frequency controller.
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_dpll_freq_ctrl;

  localparam int DIV_W    = 5;
  localparam int CNT_W    = 7;
  localparam int TOL      = 1;
  localparam int LOCK_N   = 4;
  localparam int TRIM_RST = 0;
  localparam int IDX_MAX  = 26;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_ARM   = 1;
  localparam int M_TRACK = 2;
  localparam int M_LOCK  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             osc = 1'b0;
  logic [DIV_W-1:0] div = 5'd10;
  logic [25:0]      trim;
  logic [4:0]       idx;
  logic             locked;
  logic             update;

  always #5 clk = ~clk;

  dpll_freq_ctrl #(
    .DIV_W    (DIV_W),
    .CNT_W    (CNT_W),
    .TOL      (TOL),
    .LOCK_N   (LOCK_N),
    .TRIM_RST (TRIM_RST)
  ) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .enable_i   (en),
    .osc_i      (osc),
    .div_i      (div),
    .trim_o     (trim),
    .trim_idx_o (idx),
    .locked_o   (locked),
    .update_o   (update)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] model_trim(input int i);
    logic [63:0] ones;
    ones = (64'd1 << i) - 64'd1;
    return ones[25:0];
  endfunction

  // Model state: the reference edge is seen two clocks after osc is first
  // sampled high, and each measured period is the distance between edges.
  int cyc = 0;
  int m_mode, m_idx, m_streak, m_last, m_prev;
  bit m_locked, m_upd, m_has_prev;
  bit s1, s2, s3;

  task automatic model_reset();
    m_mode = M_IDLE; m_idx = TRIM_RST; m_locked = 0; m_upd = 0;
    m_streak = 0; m_last = 0; m_prev = 0; m_has_prev = 0;
    s1 = 0; s2 = 0; s3 = 0;
  endtask

  task automatic model_step();
    bit redge;
    int c, meas, hi, lo;
    bit up, dn;
    if (rst) begin
      model_reset();
      return;
    end
    redge = s2 && !s3;
    s3 = s2; s2 = s1; s1 = osc;
    m_upd = 0;
    if (!en) begin
      m_mode = M_IDLE; m_locked = 0; m_streak = 0; m_has_prev = 0; m_prev = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_ARM;
    end else if (m_mode == M_ARM) begin
      if (redge) begin
        m_last = cyc; m_mode = M_TRACK; m_streak = 0; m_has_prev = 0;
      end
    end else if (redge) begin
      c = cyc - m_last;
      if (c > CNT_SAT) c = CNT_SAT;
      m_last = cyc;
      m_upd  = 1;
`ifdef DPLL_AVG_EN
      meas = m_has_prev ? c + m_prev : 2 * c;
      hi   = 2 * (int'(div) + TOL);
      lo   = 2 * (int'(div) - TOL);
`else
      meas = c;
      hi   = int'(div) + TOL;
      lo   = int'(div) - TOL;
`endif
      m_prev = c; m_has_prev = 1;
      up = (c == CNT_SAT) || (meas > hi);
      dn = !up && (meas < lo);
      if (up || dn) begin
        if (up && m_idx < IDX_MAX) m_idx++;
        if (dn && m_idx > 0) m_idx--;
        m_streak = 0; m_locked = 0; m_mode = M_TRACK;
      end else if (m_mode == M_TRACK) begin
        m_streak++;
        if (m_streak >= LOCK_N) begin
          m_mode = M_LOCK; m_locked = 1;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      check("trim_idx", 32'(idx), 32'(m_idx));
      check("trim", 32'(trim), 32'(model_trim(m_idx)));
      check("locked", 32'(locked), 32'(m_locked));
      check("update", 32'(update), 32'(m_upd));
      if (idx == 5'd13) check("enc13", 32'(trim), 32'h0001FFF);
      if (idx == 5'd14) check("enc14", 32'(trim), 32'h0003FFF);
      if (idx == 5'd20) check("enc20", 32'(trim), 32'h00FFFFF);
      if (idx == 5'd26) check("enc26", 32'(trim), 32'h3FFFFFF);
    end
  end

  task automatic run_period(input int p);
    for (int i = 0; i < p; i++) begin
      osc = (i < p / 2);
      @(negedge clk);
    end
  endtask

  task automatic run_n(input int p, input int n);
    for (int k = 0; k < n; k++) run_period(p);
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    check("rst_idx", 32'(idx), 32'(TRIM_RST));
    check("rst_trim", 32'(trim), 32'(model_trim(TRIM_RST)));
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_disable(input int n);
    en = 1'b0;
    repeat (n) @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    int r, p;
    check("model_enc13", 32'(model_trim(13)), 32'h0001FFF);
    check("model_enc14", 32'(model_trim(14)), 32'h0003FFF);
    check("model_enc20", 32'(model_trim(20)), 32'h00FFFFF);
    repeat (3) @(negedge clk);
    check("reset_trim", 32'(trim), 32'h0);
    check("reset_idx", 32'(idx), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Slow reference: one step up per measured period.
    en = 1'b1;
    run_n(14, 6);
    check("climb_idx", 32'(idx), 32'd5);
    check("climb_locked", 32'(locked), 32'd0);

    // Matching reference: lock after LOCK_N in-band periods.
    run_n(10, 7);
    check("lock_idx", 32'(idx), 32'd6);
    check("lock_locked", 32'(locked), 32'd1);

    // One out-of-band period drops lock.
    run_n(13, 2);
    check("unlock_idx", 32'(idx), 32'd7);
    check("unlock_locked", 32'(locked), 32'd0);

    // Upper clamp, then lower clamp.
    run_n(20, 25);
    check("clamp_hi_idx", 32'(idx), 32'd26);
    check("clamp_hi_trim", 32'(trim), 32'h3FFFFFF);
    run_n(5, 30);
    check("clamp_lo_idx", 32'(idx), 32'd0);
    check("clamp_lo_trim", 32'(trim), 32'h0);

    // Alternating 9/12 periods around div=10.
    for (int k = 0; k < 5; k++) begin
      run_period(9);
      run_period(12);
    end
`ifdef DPLL_AVG_EN
    check("alt_idx", 32'(idx), 32'd0);
`else
    check("alt_idx", 32'(idx), 32'd4);
`endif

    // Drop enable mid-track, then re-enable.
    run_n(10, 3);
    en = 1'b0;
    @(negedge clk);
    check("disable_locked", 32'(locked), 32'd0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    run_n(11, 4);

    // Reset mid-measurement.
    run_period(8);
    osc = 1'b1;
    repeat (3) @(negedge clk);
    mid_reset();
    osc = 1'b0;
    @(negedge clk);

    // Random periods, divider changes, disables and resets.
    for (int k = 0; k < 160; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) pulse_disable(int'($urandom_range(1, 6)));
      else if (r < 8) mid_reset();
      else if (r < 16) div = DIV_W'($urandom_range(0, 31));
      p = (r >= 95) ? int'($urandom_range(100, 150)) : int'($urandom_range(2, 30));
      run_period(p);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dpll_freq_ctrl.md
Name: dpll_freq_ctrl

Overview:
Frequency-locking controller directly upstream of the 13-stage trimmed ring oscillator. It counts DCO clock cycles per reference period and compares the count to a programmed divider. It steps a trim index up or down and drives the oscillator's 26-bit trim word. Clocked by the oscillator's own clockp[0]. The reference is sampled as data.

Parameters:
DIV_W, 5, width of the divider ratio input.
CNT_W, 7, width of the period counter (saturating).
TOL, 1, dead band in counts around div; no trim change inside the band.
LOCK_N, 4, consecutive in-band measurements required to assert locked.
TRIM_RST, 0, trim index loaded on reset (0..26).

Ports:
clock  in  1  DCO clock (clockp[0] of the oscillator).
reset  in  1  asynchronous, active-high reset.
enable  in  1  controller enable; low freezes the trim and returns the FSM to IDLE.
osc  in  1  reference clock, asynchronous to clock.
div  in  DIV_W  target DCO cycles per reference period.
trim  out  26  trim word to the oscillator.
trim_idx  out  5  current trim index, 0..26.
locked  out  1  frequency-lock indicator.
update  out  1  one-cycle pulse on each completed measurement.

Behaviour:
- Reset values: trim_idx=TRIM_RST, trim=encode(TRIM_RST), locked=0, update=0, counter=0, FSM=IDLE, osc synchronizer=0, in-band streak=0.
- osc passes through a 2-flop synchronizer and a third flop. A ref edge is synchronizer-out high with third-flop low. Latency from an osc rise to the ref-edge pulse is 2–3 clock cycles.
- Counter increments every cycle, saturates at 2^CNT_W-1, and loads 1 on a ref edge (that cycle starts the next period).
- FSM states:
  - IDLE: counter held at 0, trim held. On enable=1, go to ARM.
  - ARM: wait for the first ref edge. Discard the partial period, clear the counter, go to TRACK.
  - TRACK: on each ref edge, evaluate the completed count c:
    - c > div+TOL: trim_idx +1 (more delay, lower frequency).
    - c < div-TOL, computed signed so div<TOL never underflows: trim_idx -1.
    - Otherwise: no change, streak +1.
    - Any step clears the streak and drops locked.
    - When the streak reaches LOCK_N, go to LOCK and set locked=1.
  - LOCK: same evaluation. An in-band result stays in LOCK. An out-of-band result steps the trim, clears locked, and returns to TRACK.
- enable=0 in any state: go to IDLE next cycle, locked=0, trim_idx unchanged.
- trim_idx clamps at 0 and 26; a step past a bound is a no-op but still counts as out-of-band.
- update pulses in the cycle after each TRACK/LOCK evaluation. trim/trim_idx change in that same cycle; both are registered.
- Trim encoding is a thermometer over primary bits first, then secondary:
  - idx ≤ 13: trim[k]=1 for k<idx, trim[25:13]=0.
  - idx > 13: trim[12:0]=all ones, trim[13+k]=1 for k<idx-13.
  - A secondary bit is therefore never set without its primary.
- Saturated counter with div at max is treated as c > div+TOL.
- reset asserted mid-measurement: all state returns to reset values immediately; no update pulse.

Optional Feature:
DPLL_AVG_EN.
- Defined: keep the previous completed count. Once TRACK has at least one prior count, evaluate s = c + c_prev against 2*div ± 2*TOL, with an adder of width CNT_W+1.
  - The first TRACK evaluation after ARM uses 2*c.
  - c_prev clears on reset and on entering IDLE.
- Undefined: single-period comparison as above. No c_prev register exists.

Decomposition:
- Package dpll_pkg:
  - TRIM_W=26, NSTAGE=13, IDX_MAX=26, IDX_W=5.
  - FSM state enum {IDLE, ARM, TRACK, LOCK}.
  - Function encode_trim(idx) returning the 26-bit thermometer word.
- One sub-module: dpll_ref_sync (2-flop synchronizer plus edge detect, async reset).

Test Plan:
- Reset with TRIM_RST=0 → trim=26'h0, trim_idx=0, locked=0. Then enable=1, div=10, osc period 14 clocks → after the ARM edge, trim_idx 1,2,3… one step per ref edge, with an update pulse on each.
- osc period 10 clocks, div=10, TOL=1, LOCK_N=4 → no trim change; locked rises on the 4th evaluated edge after ARM. A later period of 13 clocks → trim_idx +1, locked=0, FSM back to TRACK.
- Force trim_idx to 26 and keep the period long (20 clocks, div=10) → trim stays 26'h3FFFFFF with no wrap. At idx 0 with a short period (5 clocks) → trim stays 0.
- Encoding sweep → idx=13 gives 26'h0001FFF, idx=14 gives 26'h0003FFF, idx=20 gives 26'h00FFFFF.
- enable drops mid-TRACK → next cycle IDLE, locked=0, trim held. Re-enable → the first ref edge is discarded (no update pulse).
- DPLL_AVG_EN, div=10, alternating periods 9/12 → sums 21, 21 fall within 20±2, so no steps. Without the macro, the same stimulus with TOL=1 steps +1 on each 12-period and holds on each 9-period.
